// File: rtl/dp_exec_seq_if.sv
// Bus bundle for the data-processing issue engine: instruction handshake,
// register-file ports, shifter and ALU drive, and writeback/status.
interface dp_exec_seq_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [3:0]  cpsr_flags_in;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic [3:0]  rf_raddr_c;
  logic [31:0] rf_rdata_a;
  logic [31:0] rf_rdata_b;
  logic [31:0] rf_rdata_c;
  logic [31:0] sh_value;
  logic [1:0]  sh_type;
  logic [7:0]  sh_amount;
  logic        sh_imm_form;
  logic        sh_carry_in;
  logic [31:0] sh_result;
  logic        sh_carry;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_shift_carry;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cpsr_we;
  logic [3:0]  cpsr_flags_out;
  logic        done;
  logic        cond_failed;
  logic        unsupported;
  logic        pc_written;

  modport master (
    output instr_valid, instr, cpsr_flags_in,
    output rf_rdata_a, rf_rdata_b, rf_rdata_c,
    output sh_result, sh_carry, alu_result, alu_flags,
    input  instr_ready, rf_raddr_a, rf_raddr_b, rf_raddr_c,
    input  sh_value, sh_type, sh_amount, sh_imm_form, sh_carry_in,
    input  alu_op, alu_a, alu_b, alu_shift_carry,
    input  rf_we, rf_waddr, rf_wdata, cpsr_we, cpsr_flags_out,
    input  done, cond_failed, unsupported, pc_written
  );

  modport slave (
    input  instr_valid, instr, cpsr_flags_in,
    input  rf_rdata_a, rf_rdata_b, rf_rdata_c,
    input  sh_result, sh_carry, alu_result, alu_flags,
    output instr_ready, rf_raddr_a, rf_raddr_b, rf_raddr_c,
    output sh_value, sh_type, sh_amount, sh_imm_form, sh_carry_in,
    output alu_op, alu_a, alu_b, alu_shift_carry,
    output rf_we, rf_waddr, rf_wdata, cpsr_we, cpsr_flags_out,
    output done, cond_failed, unsupported, pc_written
  );
endinterface

// File: rtl/dp_exec_seq.sv
// Multi-cycle issue/sequencing engine for ARM data-processing instructions:
// condition check, operand read, shifter operand, ALU drive, writeback.
module dp_exec_seq #(
  parameter bit RS_WAIT  = 1'b1,
  parameter bit NV_NEVER = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  dp_exec_seq_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, READ, SHIFT, RWAIT, EXEC, WB
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rn_q, rn_d;
  logic [31:0] rm_q, rm_d;
  logic [31:0] op_q, op_d;
  logic [31:0] res_q, res_d;
  logic [7:0]  rs_q, rs_d;
  logic [3:0]  flg_q, flg_d;
  logic        c_q, c_d;
  logic        shc_q, shc_d;
  logic        fail_q, fail_d;
  logic        unsup_q, unsup_d;

  logic        n_f, z_f, c_f, v_f, cond_ok;
  logic        i_bit, s_bit, is_test, unsup;
  logic [63:0] imm_x;
  logic [31:0] imm_op;
  logic        in_wb, wr_ok, rf_we_w;
  logic        unused_rs_hi;

  assign i_bit   = ir_q[25];
  assign s_bit   = ir_q[20];
  assign is_test = ir_q[24:23] == 2'b10;
  assign unsup   = (ir_q[27:26] != 2'b00)
                 | (!i_bit & ir_q[7] & ir_q[4])
                 | (is_test & !s_bit)
                 | ((ir_q[15:12] == 4'hF) & s_bit);

  // Rotating a doubled copy right gives imm8 ROR (2*rot) in the low word
  assign imm_x  = {24'd0, ir_q[7:0], 24'd0, ir_q[7:0]}
                >> {ir_q[11:8], 1'b0};
  assign imm_op = imm_x[31:0];

  assign unused_rs_hi = ^bus.rf_rdata_c[31:8];

  always_comb begin
    {n_f, z_f, c_f, v_f} = bus.cpsr_flags_in;
    cond_ok = 1'b0;
    unique case (ir_q[31:28])
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f & !z_f;
      4'h9: cond_ok = !c_f | z_f;
      4'hA: cond_ok = n_f == v_f;
      4'hB: cond_ok = n_f != v_f;
      4'hC: cond_ok = !z_f & (n_f == v_f);
      4'hD: cond_ok = z_f | (n_f != v_f);
      4'hE: cond_ok = 1'b1;
      4'hF: cond_ok = !NV_NEVER;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    op_d    = op_q;
    res_d   = res_q;
    rs_d    = rs_q;
    flg_d   = flg_q;
    c_d     = c_q;
    shc_d   = shc_q;
    fail_d  = fail_q;
    unsup_d = unsup_q;
    unique case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = READ;
        end
      end
      READ: begin
        rn_d    = bus.rf_rdata_a;
        rm_d    = bus.rf_rdata_b;
        rs_d    = bus.rf_rdata_c[7:0];
        c_d     = bus.cpsr_flags_in[1];
        fail_d  = !cond_ok;
        unsup_d = unsup;
        state_d = (!cond_ok || unsup) ? WB : SHIFT;
      end
      SHIFT: begin
        if (i_bit) begin
          op_d  = imm_op;
          shc_d = (ir_q[11:8] == 4'd0) ? c_q : imm_op[31];
        end else begin
          op_d  = bus.sh_result;
          shc_d = bus.sh_carry;
        end
        state_d = (RS_WAIT && !i_bit && ir_q[4]) ? RWAIT : EXEC;
      end
      RWAIT: state_d = EXEC;
      EXEC: begin
        res_d   = bus.alu_result;
        flg_d   = bus.alu_flags;
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      rs_q    <= '0;
      flg_q   <= '0;
      c_q     <= 1'b0;
      shc_q   <= 1'b0;
      fail_q  <= 1'b0;
      unsup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      op_q    <= op_d;
      res_q   <= res_d;
      rs_q    <= rs_d;
      flg_q   <= flg_d;
      c_q     <= c_d;
      shc_q   <= shc_d;
      fail_q  <= fail_d;
      unsup_q <= unsup_d;
    end
  end

  assign in_wb   = state_q == WB;
  assign wr_ok   = in_wb & !fail_q & !unsup_q;
  assign rf_we_w = wr_ok & !is_test;

  assign bus.instr_ready     = state_q == IDLE;
  assign bus.rf_raddr_a      = ir_q[19:16];
  assign bus.rf_raddr_b      = ir_q[3:0];
  assign bus.rf_raddr_c      = ir_q[11:8];
  assign bus.sh_value        = rm_q;
  assign bus.sh_type         = ir_q[6:5];
  assign bus.sh_amount       = ir_q[4] ? rs_q : {3'd0, ir_q[11:7]};
  assign bus.sh_imm_form     = ((state_q == SHIFT) || (state_q == RWAIT))
                             & !ir_q[4];
  assign bus.sh_carry_in     = c_q;
  assign bus.alu_op          = ir_q[24:21];
  assign bus.alu_a           = rn_q;
  assign bus.alu_b           = op_q;
  assign bus.alu_shift_carry = shc_q;
  assign bus.rf_we           = rf_we_w;
  assign bus.rf_waddr        = ir_q[15:12];
  assign bus.rf_wdata        = res_q;
  assign bus.cpsr_we         = wr_ok & s_bit;
  assign bus.cpsr_flags_out  = flg_q;
  assign bus.done            = in_wb;
  assign bus.cond_failed     = in_wb & fail_q & !unsup_q;
  assign bus.unsupported     = in_wb & unsup_q;
  assign bus.pc_written      = rf_we_w & (ir_q[15:12] == 4'hF);
endmodule

// File: tb/tb_dp_exec_seq.sv
// Directed bench for dp_exec_seq: behavioural regfile, shifter and ALU
// around the engine, a vector table, and reset/register-shift sequences.
module tb_dp_exec_seq;
  logic clk;
  logic rst_n;
  dp_exec_seq_if bus ();

  dp_exec_seq #(.RS_WAIT(1'b1), .NV_NEVER(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] regs [16];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [32:0] shf(input logic [31:0] v,
                                      input logic [1:0] t,
                                      input logic [7:0] a,
                                      input logic im, input logic ci);
    int n;
    logic [31:0] r;
    n = int'(a);
    if (im && n == 0) begin
      case (t)
        2'd0:    return {ci, v};
        2'd1:    return {v[31], 32'd0};
        2'd2:    return {v[31], {32{v[31]}}};
        default: return {v[0], ci, v[31:1]};
      endcase
    end
    if (n == 0) return {ci, v};
    if (n >= 32) begin
      case (t)
        2'd0: return {(n == 32) ? v[0] : 1'b0, 32'd0};
        2'd1: return {(n == 32) ? v[31] : 1'b0, 32'd0};
        2'd2: return {v[31], {32{v[31]}}};
        default: begin
          n = n % 32;
          if (n == 0) return {v[31], v};
        end
      endcase
    end
    case (t)
      2'd0: return {v[32-n], v << n};
      2'd1: return {v[n-1], v >> n};
      2'd2: begin
        r = $signed(v) >>> n;
        return {v[n-1], r};
      end
      default: return {v[n-1], (v >> n) | (v << (32 - n))};
    endcase
  endfunction

  function automatic logic [35:0] alu(input logic [3:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic sc);
    logic [31:0] x, y, r;
    logic [32:0] s;
    logic arith, cc, vv;
    arith = 1'b1;
    x = a;
    y = b;
    s = '0;
    r = '0;
    case (op)
      4'd2, 4'd6, 4'd10: begin y = ~b; s = {1'b0, a} + {1'b0, ~b} + 33'd1; end
      4'd3, 4'd7: begin x = b; y = ~a; s = {1'b0, b} + {1'b0, ~a} + 33'd1; end
      4'd4, 4'd5, 4'd11: s = {1'b0, a} + {1'b0, b};
      default: arith = 1'b0;
    endcase
    if (arith) begin
      r  = s[31:0];
      cc = s[32];
      vv = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      case (op)
        4'd0, 4'd8:  r = a & b;
        4'd1, 4'd9:  r = a ^ b;
        4'd12:       r = a | b;
        4'd13:       r = b;
        4'd14:       r = a & ~b;
        default:     r = ~b;
      endcase
      cc = sc;
      vv = 1'b0;
    end
    return {r[31], r == 32'd0, cc, vv, r};
  endfunction

  always_comb begin
    bus.rf_rdata_a = regs[bus.rf_raddr_a];
    bus.rf_rdata_b = regs[bus.rf_raddr_b];
    bus.rf_rdata_c = regs[bus.rf_raddr_c];
    {bus.sh_carry, bus.sh_result} = shf(bus.sh_value, bus.sh_type,
      bus.sh_amount, bus.sh_imm_form, bus.sh_carry_in);
    {bus.alu_flags, bus.alu_result} = alu(bus.alu_op, bus.alu_a,
      bus.alu_b, bus.alu_shift_carry);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] w, input logic [3:0] f);
    @(negedge clk);
    bus.cpsr_flags_in = f;
    bus.instr = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  // Leaves the caller at the negedge of the done cycle (lat=0: timeout)
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    string       nm;
    logic [31:0] w;
    logic [3:0]  f;
    int          lat;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        cwe;
    logic [3:0]  fl;
    logic        shc;
    logic        cf;
    logic        un;
    logic        pc;
  } vec_t;

  vec_t tv [14];

  initial begin
    int lat;
    int bad;
    for (int r = 0; r < 16; r++) regs[r] = 32'h1000 + r;
    regs[1] = 32'hFFFF_FFFF;
    regs[2] = 32'd1;
    regs[3] = 32'd4;
    regs[4] = 32'h80;

    tv[0]  = '{"adds",    32'hE0910002, 4'h0, 4, 1, 4'h0, 32'h0,        1, 4'h6, 0, 0, 0, 0};
    tv[1]  = '{"mov_imm", 32'hE3A034FF, 4'h0, 4, 1, 4'h3, 32'hFF000000, 0, 4'h0, 1, 0, 0, 0};
    tv[2]  = '{"cmp",     32'hE1540004, 4'h0, 4, 0, 4'h0, 32'h0,        1, 4'h6, 0, 0, 0, 0};
    tv[3]  = '{"addne",   32'h10810002, 4'h4, 2, 0, 4'h0, 32'h0,        0, 4'h0, 0, 1, 0, 0};
    tv[4]  = '{"add_rs",  32'hE0810312, 4'h0, 5, 1, 4'h0, 32'h0000000F, 0, 4'h0, 0, 0, 0, 0};
    tv[5]  = '{"mul",     32'hE0000291, 4'h0, 2, 0, 4'h0, 32'h0,        0, 4'h0, 0, 0, 1, 0};
    tv[6]  = '{"nv",      32'hF0810002, 4'h0, 2, 0, 4'h0, 32'h0,        0, 4'h0, 0, 1, 0, 0};
    tv[7]  = '{"mrs",     32'hE10F0000, 4'h0, 2, 0, 4'h0, 32'h0,        0, 4'h0, 0, 0, 1, 0};
    tv[8]  = '{"movs_pc", 32'hE1B0F002, 4'h0, 2, 0, 4'h0, 32'h0,        0, 4'h0, 0, 0, 1, 0};
    tv[9]  = '{"mov_pc",  32'hE1A0F002, 4'h0, 4, 1, 4'hF, 32'h1,        0, 4'h0, 0, 0, 0, 1};
    tv[10] = '{"ldr",     32'hE5910000, 4'h0, 2, 0, 4'h0, 32'h0,        0, 4'h0, 0, 0, 1, 0};
    tv[11] = '{"add_lsl", 32'hE0810182, 4'h0, 4, 1, 4'h0, 32'h7,        0, 4'h0, 0, 0, 0, 0};
    tv[12] = '{"addseq",  32'h00910002, 4'h4, 4, 1, 4'h0, 32'h0,        1, 4'h6, 0, 0, 0, 0};
    tv[13] = '{"ands_lsr",32'hE01150A2, 4'h0, 4, 1, 4'h5, 32'h0,        1, 4'h6, 1, 0, 0, 0};

    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.cpsr_flags_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_we", {30'd0, bus.rf_we, bus.cpsr_we}, 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      issue(tv[i].w, tv[i].f);
      wait_done(lat);
      chk({tv[i].nm, "_lat"}, lat, tv[i].lat);
      chk({tv[i].nm, "_we"}, {31'd0, bus.rf_we}, {31'd0, tv[i].we});
      chk({tv[i].nm, "_cwe"}, {31'd0, bus.cpsr_we}, {31'd0, tv[i].cwe});
      chk({tv[i].nm, "_cf"}, {31'd0, bus.cond_failed}, {31'd0, tv[i].cf});
      chk({tv[i].nm, "_un"}, {31'd0, bus.unsupported}, {31'd0, tv[i].un});
      chk({tv[i].nm, "_pc"}, {31'd0, bus.pc_written}, {31'd0, tv[i].pc});
      if (tv[i].we) begin
        chk({tv[i].nm, "_wa"}, {28'd0, bus.rf_waddr}, {28'd0, tv[i].wa});
        chk({tv[i].nm, "_wd"}, bus.rf_wdata, tv[i].wd);
      end
      if (tv[i].cwe)
        chk({tv[i].nm, "_fl"}, {28'd0, bus.cpsr_flags_out}, {28'd0, tv[i].fl});
      if (tv[i].lat >= 4)
        chk({tv[i].nm, "_shc"}, {31'd0, bus.alu_shift_carry}, {31'd0, tv[i].shc});
    end

    // Register-specified shift: shifter drive seen during SHIFT
    issue(32'hE0810312, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rs_amount", {24'd0, bus.sh_amount}, 32'd4);
    chk("rs_immform", {31'd0, bus.sh_imm_form}, 32'd0);
    chk("rs_value", bus.sh_value, 32'd1);
    wait_done(lat);
    chk("rs_lat_rem", lat, 32'd3);
    chk("rs_wd", bus.rf_wdata, 32'h0000000F);

    // Immediate-shift form flagged during SHIFT
    issue(32'hE0810182, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("imm_immform", {31'd0, bus.sh_imm_form}, 32'd1);
    chk("imm_amount", {24'd0, bus.sh_amount}, 32'd3);
    wait_done(lat);

    // Reset while in EXEC abandons the instruction
    issue(32'hE0910002, 4'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("exec_alu_a", bus.alu_a, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    @(negedge clk);
    bad = 0;
    if (bus.done || bus.rf_we || bus.cpsr_we) bad++;
    rst_n = 1'b1;
    chk("mid_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("mid_alu_a", bus.alu_a, 32'd0);
    chk("mid_flags", {28'd0, bus.cpsr_flags_out}, 32'd0);
    chk("mid_raddr", {28'd0, bus.rf_raddr_a}, 32'd0);
    chk("mid_wdata", bus.rf_wdata, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done || bus.rf_we || bus.cpsr_we) bad++;
    end
    chk("mid_no_wr", bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dp_exec_seq.md
Name: dp_exec_seq

Overview:
Issue and sequencing engine for ARM data-processing instructions, sitting on the driving side of the core ALU. It accepts one instruction word and evaluates its condition code. It then reads operands from the register file, forms the shifter operand (immediate-rotate internally, register shifts through the external barrel shifter), drives the ALU, and writes back Rd and the CPSR flags. It is a multi-cycle FSM and handles one instruction at a time.

Parameters:
RS_WAIT, 1, when 1 a register-specified shift (I=0, ir[4]=1) inserts one extra internal cycle (ARM7 I-cycle); when 0 no extra cycle.
NV_NEVER, 1, when 1 condition 4'b1111 always fails; when 0 it is treated as AL.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction word offered
instr  in  32  ARM instruction word
instr_ready  out  1  engine idle, can accept
cpsr_flags_in  in  4  current {N,Z,C,V}
rf_raddr_a  out  4  Rn address (ir[19:16])
rf_raddr_b  out  4  Rm address (ir[3:0])
rf_raddr_c  out  4  Rs address (ir[11:8])
rf_rdata_a  in  32  Rn data, combinational read; PC offset supplied by register file
rf_rdata_b  in  32  Rm data
rf_rdata_c  in  32  Rs data
sh_value  out  32  shifter input (captured Rm)
sh_type  out  2  ir[6:5]: LSL/LSR/ASR/ROR
sh_amount  out  8  ir[11:7] zero-extended, or Rs[7:0]
sh_imm_form  out  1  1 = immediate-encoded amount (#0 means LSR/ASR 32, ROR = RRX)
sh_carry_in  out  1  CPSR C
sh_result  in  32  shifted operand
sh_carry  in  1  shifter carry-out
alu_op  out  4  ir[24:21]
alu_a  out  32  captured Rn
alu_b  out  32  captured shifter operand
alu_shift_carry  out  1  captured shifter carry
alu_result  in  32  ALU result
alu_flags  in  4  ALU {N,Z,C,V}
rf_we  out  1  register write strobe (one cycle)
rf_waddr  out  4  Rd (ir[15:12])
rf_wdata  out  32  result
cpsr_we  out  1  flag write strobe (one cycle)
cpsr_flags_out  out  4  new {N,Z,C,V}
done  out  1  one-cycle completion pulse
cond_failed  out  1  valid with done: condition failed, no writes
unsupported  out  1  valid with done: not a supported DP encoding, no writes
pc_written  out  1  valid with done: Rd=15 was written

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. All strobes, flags, and registered data outputs go to 0. Any in-flight instruction is abandoned with no writes and no done. instr is ignored while rst_n=0.
- instr_ready = (state==IDLE). Accept on valid&&ready; ir <= instr.
- States: IDLE -> READ -> SHIFT -> [RWAIT] -> EXEC -> WB -> IDLE.
- READ: read addresses driven from ir; capture Rn, Rm, Rs[7:0]; evaluate the condition against cpsr_flags_in (EQ..LE standard, AL pass, NV per NV_NEVER). Classify the encoding as unsupported when any of the following holds:
  - ir[27:26]!=00;
  - I=0 && ir[7]=1 && ir[4]=1 (multiply/extra load-store space);
  - opcode in TST..CMN with S=0 (MRS/MSR);
  - Rd=15 with S=1 (SPSR restore is out of scope).
- Fail or unsupported goes straight to WB with writes suppressed.
- SHIFT, I=1: operand = imm8 ROR (2*rot). Carry = CPSR C if rot==0, else operand[31].
- SHIFT, I=0: drive the shifter and capture sh_result/sh_carry. RWAIT is entered only for a register shift with RS_WAIT=1.
- EXEC: drive the ALU from the captured registers; capture alu_result and alu_flags.
- WB (one cycle, done=1):
  - rf_we=1 unless the opcode is TST/TEQ/CMP/CMN.
  - cpsr_we = S.
  - pc_written = rf_we && Rd==15.
  - Strobes are 0 in every other state.
- Latency from the accept edge to done: 4 cycles normally, 5 with RWAIT, 2 for cond-fail or unsupported. A back-to-back accept is possible on the cycle after done.
- CPSR is sampled only in READ; the caller must not change it mid-instruction.

Test Plan:
- Reset mid-EXEC with rst_n=0 for one cycle -> no rf_we/cpsr_we/done; instr_ready=1 the next cycle; all outputs 0.
- ADDS R0,R1,R2 with R1=0xFFFFFFFF, R2=1 -> done at cycle 4; rf_wdata=0, waddr=0, cpsr_flags_out=0110, cpsr_we=1.
- MOV R3,#0xFF ROR 8 (rot=4) with CPSR C=0 -> rf_wdata=0xFF000000; alu_shift_carry=1; cpsr_we=0.
- CMP R4,R4 with S=1 -> rf_we=0, cpsr_we=1, flags Z=1 C=1.
- ADDNE with Z=1 -> done at cycle 2 with cond_failed=1, no writes.
- ADD R0,R1,R2,LSL R3 with R3=4, RS_WAIT=1 -> sh_amount=4, done at cycle 5.
- Word 0xE0000291 (MUL) -> done at cycle 2 with unsupported=1.
